// File: rtl/uart_block_link.sv
// uart_block_link: 8N1 UART receiver assembling BLOCK_BYTES-byte blocks, byte-selectable readout, optional block echo on tx.
// Latency: block_valid/frame_err one cycle after the stop sample; port_out one cycle after block_valid or a sel change.
// Backpressure: none; a block completing mid-echo still updates block_data, is not echoed, and pulses tx_overrun.
module uart_block_link #(
  parameter int CLK_DIV      = 434,
  parameter int BLOCK_BYTES  = 8,
  parameter int SEL_W        = 3,
  parameter int TIMEOUT_BITS = 32,
  parameter int ECHO         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic                     tx,
  input  logic [SEL_W-1:0]         sel,
  output logic [7:0]               port_out,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic                     block_valid,
  output logic                     frame_err,
  output logic                     timeout,
  output logic                     tx_busy,
  output logic                     tx_overrun
);

  localparam int          DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(BLOCK_BYTES - 1);
  localparam bit          TO_EN     = (TIMEOUT_BITS > 0);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_BITS * CLK_DIV - 1);
  localparam bit          ECHO_EN   = (ECHO != 0);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // rx synchronizer and edge history
  logic rx_meta;
  logic rxs;
  logic rxs_d;
  logic start_edge;

  // receiver state
  rx_state_t                rx_state;
  logic [DIV_W-1:0]         rx_cnt;
  logic [2:0]               rx_bit;
  logic [7:0]               rx_shift;
  logic [SEL_W-1:0]         byte_cnt;
  logic [31:0]              idle_cnt;
  logic [8*BLOCK_BYTES-1:0] asm_buf;
  logic [8*BLOCK_BYTES-1:0] asm_next;

  // transmitter state
  tx_state_t                tx_state;
  logic [DIV_W-1:0]         tx_cnt;
  logic [2:0]               tx_bit;
  logic [SEL_W-1:0]         tx_idx;
  logic [8*BLOCK_BYTES-1:0] tx_shadow;

  assign start_edge = rxs_d & ~rxs;

  // Two-flop synchronizer on rx plus one more stage for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // Assembly buffer with the just-received byte dropped into the current slot.
  always_comb begin
    asm_next = asm_buf;
    asm_next[8*byte_cnt +: 8] = rx_shift;
  end

  // Receive FSM: start qualification, bit sampling, stop check, block assembly and inter-byte timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      asm_buf     <= '0;
      block_data  <= '0;
      block_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      block_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      idle_cnt    <= '0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          // idle time only matters while a block is partially assembled
          if (TO_EN && byte_cnt != '0) begin
            if (idle_cnt == TO_LAST) begin
              timeout  <= 1'b1;
              byte_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
          // a start edge coinciding with expiry still begins a frame, which lands in slot 0
          if (start_edge) begin
            rx_state <= RX_START;
            idle_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxs, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rxs) begin
              asm_buf <= asm_next;
              if (byte_cnt == LAST_SLOT) begin
                block_data  <= asm_next;
                block_valid <= 1'b1;
                byte_cnt    <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              // bad stop bit: drop the partial block
              frame_err <= 1'b1;
              byte_cnt  <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Live byte select of the latched block, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_out <= '0;
    end else if (32'(sel) < BLOCK_BYTES) begin
      port_out <= block_data[8*sel +: 8];
    end else begin
      port_out <= '0;
    end
  end

  // Echo FSM: sends the shadowed block byte by byte in 8N1; busy exactly while not idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_idx     <= '0;
      tx_shadow  <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      tx_overrun <= ECHO_EN && block_valid && tx_busy;
      case (tx_state)
        TX_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
          if (ECHO_EN && block_valid) begin
            tx_shadow <= block_data;
            tx_idx    <= '0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shadow[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx     <= tx_shadow[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_SLOT) begin
              tx_busy  <= 1'b0;
              tx_state <= TX_IDLE;
            end else begin
              // next byte moves into the low lane of the shadow
              tx_idx    <= tx_idx + 1'b1;
              tx_shadow <= tx_shadow >> 8;
              tx        <= 1'b0;
              tx_state  <= TX_START;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
